// File: rtl/fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : fdiv_seq
// Description : Sequential IEEE754 single-precision divider (op = a / b).
//               25-iteration restoring mantissa division, start/busy/done
//               handshake, truncating, no denormals, mod-256 exponent.
// Revision    : 1.0 - initial release
// ============================================================================
module fdiv_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] op,
    output logic        busy,
    output logic        done,
    output logic        dz
);

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_BUSY    = 1'b1;
    localparam logic [4:0] C_LAST_IT = 5'd24;

    logic [0:0]  r_state;
    logic [0:0]  w_state_next;
    logic        w_accept;
    logic        w_last;

    logic        r_sign;
    logic [7:0]  r_ea;
    logic [7:0]  r_eb;
    logic [23:0] r_mb;
    logic [24:0] r_rem;
    logic [24:0] r_q;
    logic [4:0]  r_cnt;
    logic        r_za;
    logic        r_zb;

    logic [31:0] r_op;
    logic        r_done;
    logic        r_dz;

    logic        w_ge;
    logic [24:0] w_sel;
    logic [24:0] w_rem_next;
    logic [24:0] w_q_next;
    logic [7:0]  w_exp_diff;
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic [31:0] w_result;

    assign op   = r_op;
    assign done = r_done;
    assign dz   = r_dz;
    assign busy = (r_state == S_BUSY);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: accept in IDLE, return to IDLE after the 25th iteration
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_last       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = S_BUSY;
                end
            end
            S_BUSY: begin
                if (r_cnt == C_LAST_IT) begin
                    w_last       = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // One restoring step plus normalisation of the completed quotient
    always_comb begin
        w_ge       = (r_rem >= {1'b0, r_mb});
        w_sel      = w_ge ? (r_rem - {1'b0, r_mb}) : r_rem;
        w_rem_next = {w_sel[23:0], 1'b0};
        w_q_next   = r_q | (w_ge ? (25'd1 << (C_LAST_IT - r_cnt)) : 25'd0);
        w_exp_diff = r_ea - r_eb;
        if (w_q_next[24]) begin
            w_exp  = w_exp_diff + 8'd127;
            w_frac = w_q_next[23:1];
        end else begin
            w_exp  = w_exp_diff + 8'd126;
            w_frac = w_q_next[22:0];
        end
        // Divide-by-zero wins over a zero dividend (covers 0/0)
        if (r_zb) begin
            w_result = {r_sign, 8'hFF, 23'd0};
        end else if (r_za) begin
            w_result = 32'd0;
        end else begin
            w_result = {r_sign, w_exp, w_frac};
        end
    end

    // Operand capture, iteration registers and result/flag outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
            r_ea   <= 8'd0;
            r_eb   <= 8'd0;
            r_mb   <= 24'd0;
            r_rem  <= 25'd0;
            r_q    <= 25'd0;
            r_cnt  <= 5'd0;
            r_za   <= 1'b0;
            r_zb   <= 1'b0;
            r_op   <= 32'd0;
            r_done <= 1'b0;
            r_dz   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sign <= a[31] ^ b[31];
                r_ea   <= a[30:23];
                r_eb   <= b[30:23];
                r_mb   <= {1'b1, b[22:0]};
                r_rem  <= {1'b0, 1'b1, a[22:0]};
                r_q    <= 25'd0;
                r_cnt  <= 5'd0;
                r_za   <= (a == 32'd0);
                r_zb   <= (b == 32'd0);
            end else if (r_state == S_BUSY) begin
                r_rem <= w_rem_next;
                r_q   <= w_q_next;
                r_cnt <= r_cnt + 5'd1;
                if (w_last) begin
                    r_op   <= w_result;
                    r_dz   <= r_zb;
                    r_done <= 1'b1;
                    r_cnt  <= 5'd0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fdiv_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_fdiv_seq
// Description : Self-checking bench for fdiv_seq: directed and random
//               divisions against an integer-division reference model,
//               handshake and reset behaviour.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fdiv_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] op;
    logic        busy;
    logic        done;
    logic        dz;

    int n_cmp;
    int n_err;

    fdiv_seq u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .op    (op),
        .busy  (busy),
        .done  (done),
        .dz    (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: quotient mantissa as floor(ma * 2^24 / mb), then normalise
    function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] o, output logic z);
        logic [63:0] ma;
        logic [63:0] mb;
        logic [63:0] q;
        logic [7:0]  e;
        logic        s;
        s = x[31] ^ y[31];
        if (y == 32'd0) begin
            o = {s, 8'hFF, 23'd0};
            z = 1'b1;
        end else if (x == 32'd0) begin
            o = 32'd0;
            z = 1'b0;
        end else begin
            ma = 64'd0;
            mb = 64'd0;
            ma[23:0] = {1'b1, x[22:0]};
            mb[23:0] = {1'b1, y[22:0]};
            q = (ma << 24) / mb;
            if (q >= 64'h1000000) begin
                e = x[30:23] - y[30:23] + 8'd127;
                o = {s, e, q[23:1]};
            end else begin
                e = x[30:23] - y[30:23] + 8'd126;
                o = {s, e, q[22:0]};
            end
            z = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single division with latency, result and handshake checks
    task automatic do_div(input string tag, input logic [31:0] ta, input logic [31:0] tb_v);
        logic [31:0] e_op;
        logic        e_dz;
        int          cyc;
        model(ta, tb_v, e_op, e_dz);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
        cyc = 0;
        while (!done && cyc < 40) begin
            tick();
            cyc++;
        end
        chk({tag, "_lat"}, cyc, 32'd25);
        chk({tag, "_op"}, op, e_op);
        chk({tag, "_dz"}, {31'd0, dz}, {31'd0, e_dz});
        chk({tag, "_busy0"}, {31'd0, busy}, 32'd0);
        tick();
        chk({tag, "_done0"}, {31'd0, done}, 32'd0);
        chk({tag, "_hold"}, op, e_op);
    endtask

    initial begin
        logic [31:0] e1;
        logic [31:0] e2;
        logic        ez;
        logic        seen;
        logic [31:0] ra;
        logic [31:0] rb;
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        tick();
        tick();
        chk("rst_op", op, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_dz", {31'd0, dz}, 32'd0);
        rst = 1'b0;
        tick();

        do_div("6div2", 32'h40C00000, 32'h40000000);
        chk("6div2_const", op, 32'h40400000);
        do_div("1div3", 32'h3F800000, 32'h40400000);
        chk("1div3_const", op, 32'h3EAAAAAA);
        do_div("m75div25", 32'hC0F00000, 32'h40200000);
        chk("m75div25_const", op, 32'hC0400000);
        do_div("zero_a", 32'h00000000, 32'h40000000);
        do_div("b_zero", 32'h3F800000, 32'h00000000);
        chk("b_zero_const", op, 32'h7F800000);
        do_div("nb_zero", 32'hBF800000, 32'h00000000);
        chk("nb_zero_const", op, 32'hFF800000);
        do_div("zero_zero", 32'h00000000, 32'h00000000);
        do_div("negz_b", 32'h40400000, 32'h80000000);

        for (int i = 0; i < 12; i++) begin
            ra = $urandom;
            rb = $urandom;
            do_div("rand", ra, rb);
        end

        // start pulsed mid-operation must be ignored
        model(32'h40C00000, 32'h40000000, e1, ez);
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        seen = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 5) begin
                start = 1'b1;
                a = 32'h3F800000;
                b = 32'h40400000;
            end
            if (c == 6) start = 1'b0;
            tick();
            if (c == 25) begin
                chk("ign_done", {31'd0, done}, 32'd1);
                chk("ign_op", op, e1);
            end else if (done) begin
                seen = 1'b1;
            end
        end
        chk("ign_extra_done", {31'd0, seen}, 32'd0);

        // start held high through the done cycle: back-to-back results
        model(32'hC0F00000, 32'h40200000, e1, ez);
        model(32'h3F800000, 32'h40400000, e2, ez);
        a = 32'hC0F00000;
        b = 32'h40200000;
        start = 1'b1;
        tick();
        a = 32'h3F800000;
        b = 32'h40400000;
        for (int c = 1; c <= 51; c++) begin
            tick();
            if (c == 25) begin
                chk("b2b_done1", {31'd0, done}, 32'd1);
                chk("b2b_op1", op, e1);
            end
            if (c == 50) chk("b2b_done_pre", {31'd0, done}, 32'd0);
        end
        start = 1'b0;
        chk("b2b_done2", {31'd0, done}, 32'd1);
        chk("b2b_op2", op, e2);
        tick();

        // reset mid-operation discards the division
        a = 32'h40C00000;
        b = 32'h40000000;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 9; c++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_op", op, 32'd0);
        chk("mrst_dz", {31'd0, dz}, 32'd0);
        seen = 1'b0;
        for (int c = 11; c <= 30; c++) begin
            tick();
            if (done) seen = 1'b1;
        end
        chk("mrst_no_done", {31'd0, seen}, 32'd0);

        // reset and start on the same edge: reset wins
        start = 1'b1;
        rst   = 1'b1;
        tick();
        start = 1'b0;
        rst   = 1'b0;
        chk("rst_start_busy", {31'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
